montgomery_reduce_pipe: RTL and testbench
=========================================

// Module: montgomery_reduce_pipe
// PURPOSE
//  Parametrised iterative Montgomery reduction: returns x*R^-1 mod m, with R = 2^R_LOG2.
//  Retires RADIX_LOG2 bits of R per cycle.
//  Uses valid/ready handshakes on input and output, and applies the final conditional subtraction.
//  Sits after the NTT butterfly multiplier; reduces double-width products back into [0, m).
// PARAMETERS
//  DATA_W      64  modulus / result width in bits
//  R_LOG2      64  Montgomery exponent; must be a multiple of RADIX_LOG2 and satisfy R_LOG2 >= DATA_W
//  RADIX_LOG2  1   bits retired per REDUCE cycle (1, 2, 4 or 8)
// PORTS
//  clk_i        in   1             clock
//  rst_ni       in   1             asynchronous active-low reset
//  in_valid_i   in   1             operand valid
//  in_ready_o   out  1             block can accept an operand (high only in IDLE)
//  x_i          in   2*DATA_W      value to reduce; caller guarantees x < m*R
//  m_i          in   DATA_W        modulus; must be odd
//  mprime_i     in   RADIX_LOG2    -m^-1 mod 2^RADIX_LOG2 (ignored when RADIX_LOG2 = 1)
//  out_valid_o  out  1             result valid
//  out_ready_i  in   1             downstream accepts result
//  result_o     out  DATA_W        x*R^-1 mod m, in [0, m); 0 when out_valid_o is low
//  err_o        out  1             even modulus rejected; qualified by out_valid_o
// BEHAVIOUR
//  - Reset (async assert, synchronous-release use): state IDLE, accumulator/counter/latched operands = 0.
//    Reset values: in_ready_o = 1, out_valid_o = 0, result_o = 0, err_o = 0.
//  - FSM states: IDLE, REDUCE, CORRECT, DONE.
//  - IDLE: in_ready_o = 1. When in_valid_i is high, latch x_i, m_i and mprime_i; clear the counter.
//      - Odd m: go to REDUCE.
//      - Even m: go to DONE with err = 1 and result = 0.
//  - REDUCE, one step per cycle:
//      - q = (acc[K-1:0] * mprime) mod 2^K, where K = RADIX_LOG2; for K = 1, q = acc[0].
//      - acc <= (acc + q*m) >> K.
//      - Counter increments each step; after R_LOG2/K steps go to CORRECT.
//  - Accumulator width is 2*DATA_W + RADIX_LOG2 + 1; no intermediate truncation.
//  - CORRECT (one cycle): result <= (acc >= m) ? acc - m : acc. Since acc < 2m, one subtraction suffices.
//    Then go to DONE.
//  - DONE: out_valid_o = 1; result_o and err_o held stable until out_ready_i is high.
//    On the handshake cycle go to IDLE; in_ready_o rises on the next cycle.
//  - Latency: accept at cycle 0, out_valid_o high at cycle R_LOG2/RADIX_LOG2 + 2. Throughput is 1 per latency + 1 cycles.
//  - Inputs are ignored outside IDLE; changing x_i/m_i mid-operation has no effect.
//  - out_ready_i held high while not in DONE: no effect.
//  - rst_ni low mid-operation aborts immediately; no partial result appears on output.
//  - x_i >= m*R: out of contract; result unspecified but FSM timing unchanged (no hang).
// STRUCTURE
//  - montgomery_pkg:
//      - typedef enum logic [1:0] mont_state_t {IDLE, REDUCE, CORRECT, DONE}
//      - localparam function steps(R_LOG2, RADIX_LOG2)
//      - width helper for the accumulator
//  - Sub-module montgomery_radix_step: combinational single step (acc, m, mprime -> acc_next).
//    Parametrised by DATA_W and RADIX_LOG2; instantiated once.
//  - Top holds the FSM, step counter, operand registers, final subtractor and handshakes.
// TESTING (DATA_W=8, R_LOG2=8, m=17, R mod 17 = 1 unless noted)
//  - Basic, K=1: x=256 -> result 1, err 0. out_valid exactly 10 cycles after accept; in_ready low meanwhile.
//  - Boundary, K=1:
//      - x=0 -> 0.
//      - x=4351 (m*R-1) -> 16; exercises the CORRECT subtraction path.
//  - Radix, K=2, mprime=3: x=256 -> 1 after 4 REDUCE cycles (out_valid at cycle 6).
//    Sweep all x < 4352 against a reference model.
//  - Error: m=16, x=100 -> out_valid next cycle with err_o=1, result_o=0. Next operand with m=17 processed normally.
//  - Backpressure: hold out_ready_i low 5 cycles in DONE.
//      - result_o and out_valid_o stable; in_ready_o low.
//      - Release: IDLE one cycle later; back-to-back second operand accepted.
//  - Reset: assert rst_ni in REDUCE step 3 -> all outputs at reset values same cycle.
//    Fresh operand after release yields the correct result.

Source files
------------

// File: rtl/montgomery_reduce_pipe_pkg.sv
// montgomery_pkg: shared state encoding and sizing helpers for the Montgomery reducer.
package montgomery_pkg;

    typedef enum logic [1:0] {IDLE, REDUCE, CORRECT, DONE} mont_state_t;

    function automatic int steps(input int r_log2, input int radix_log2);
        return r_log2 / radix_log2;
    endfunction

    // Room for x plus one radix digit of q*m plus the carry, so no step ever truncates.
    function automatic int acc_width(input int data_w, input int radix_log2);
        return 2 * data_w + radix_log2 + 1;
    endfunction

endpackage

// File: rtl/montgomery_reduce_pipe_radix_step.sv
// montgomery_radix_step: one combinational Montgomery step, acc -> (acc + q*m) >> K.
module montgomery_radix_step
    import montgomery_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int RADIX_LOG2 = 1
) (
    input  logic [acc_width(DATA_W, RADIX_LOG2)-1:0] acc,
    input  logic [DATA_W-1:0]                        m,
    input  logic [RADIX_LOG2-1:0]                    mprime,
    output logic [acc_width(DATA_W, RADIX_LOG2)-1:0] acc_next
);
    localparam int K  = RADIX_LOG2;
    localparam int AW = acc_width(DATA_W, RADIX_LOG2);

    logic [K-1:0]  q;
    logic [AW-1:0] sum;

    // For K = 1, -m^-1 mod 2 is always 1, so q is just the low bit.
    assign q        = (K == 1) ? acc[K-1:0] : acc[K-1:0] * mprime;
    assign sum      = acc + AW'(q) * AW'(m);
    assign acc_next = sum >> K;

endmodule

// File: rtl/montgomery_reduce_pipe.sv
// montgomery_reduce_pipe: iterative Montgomery reduction x*R^-1 mod m with valid/ready handshakes.
module montgomery_reduce_pipe
    import montgomery_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int R_LOG2     = 64,
    parameter int RADIX_LOG2 = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [2*DATA_W-1:0]   x_i,
    input  logic [DATA_W-1:0]     m_i,
    input  logic [RADIX_LOG2-1:0] mprime_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_W-1:0]     result_o,
    output logic                  err_o
);
    localparam int STEPS = steps(R_LOG2, RADIX_LOG2);
    localparam int AW    = acc_width(DATA_W, RADIX_LOG2);
    localparam int CW    = $clog2(STEPS) + 1;

    mont_state_t           state, state_nxt;
    logic [AW-1:0]         acc, acc_nxt;
    logic [DATA_W-1:0]     m_q, res_q;
    logic [RADIX_LOG2-1:0] mp_q;
    logic [CW-1:0]         cnt;
    logic                  err_q;
    logic                  last;

    assign last = (cnt == CW'(STEPS - 1));

    montgomery_radix_step #(
        .DATA_W    (DATA_W),
        .RADIX_LOG2(RADIX_LOG2)
    ) u_step (
        .acc     (acc),
        .m       (m_q),
        .mprime  (mp_q),
        .acc_next(acc_nxt)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = in_valid_i ? (m_i[0] ? REDUCE : DONE) : IDLE;
            REDUCE:  state_nxt = last ? CORRECT : REDUCE;
            CORRECT: state_nxt = DONE;
            DONE:    state_nxt = out_ready_i ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready_o  = (state == IDLE);
        out_valid_o = (state == DONE);
        result_o    = out_valid_o ? res_q : '0;
        err_o       = out_valid_o & err_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc   <= '0;
            m_q   <= '0;
            mp_q  <= '0;
            cnt   <= '0;
            res_q <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid_i) begin
                    acc   <= AW'(x_i);
                    m_q   <= m_i;
                    mp_q  <= mprime_i;
                    cnt   <= '0;
                    res_q <= '0;
                    err_q <= ~m_i[0];
                end
                REDUCE: begin
                    acc <= acc_nxt;
                    cnt <= cnt + CW'(1);
                end
                // acc < 2m here, so a single conditional subtraction lands in [0, m).
                CORRECT: res_q <= (acc >= AW'(m_q)) ? DATA_W'(acc - AW'(m_q)) : DATA_W'(acc);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_montgomery_reduce_pipe.sv
// tb_montgomery_reduce_pipe: randomized self-checking bench for radix-2 and radix-4 reducers.
module tb_montgomery_reduce_pipe;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid [2];
    logic       in_ready [2];
    logic [15:0] xs [2];
    logic [7:0]  ms [2];
    logic [1:0]  mps [2];
    logic       out_valid [2];
    logic       out_ready [2];
    logic [7:0] result [2];
    logic       err [2];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    montgomery_reduce_pipe #(.DATA_W(8), .R_LOG2(8), .RADIX_LOG2(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
        .x_i(xs[0]), .m_i(ms[0]), .mprime_i(mps[0][0]), .out_valid_o(out_valid[0]),
        .out_ready_i(out_ready[0]), .result_o(result[0]), .err_o(err[0]));

    montgomery_reduce_pipe #(.DATA_W(8), .R_LOG2(8), .RADIX_LOG2(2)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
        .x_i(xs[1]), .m_i(ms[1]), .mprime_i(mps[1]), .out_valid_o(out_valid[1]),
        .out_ready_i(out_ready[1]), .result_o(result[1]), .err_o(err[1]));

    // Reference: the unique y in [0,m) with y*2^8 == x (mod m).
    function automatic logic [7:0] ref_mont(input int x, input int m);
        for (int y = 0; y < m; y++) if ((y * 256) % m == x % m) return 8'(y);
        return 8'd0;
    endfunction

    function automatic logic [1:0] mp_of(input int m);
        return 2'((4 - m % 4) % 4);
    endfunction

    task automatic run_op(input int s, input int x, input int m, input bit hold,
                          output logic [7:0] res, output logic er, output int lat, output bit rdy_ok);
        int t = 0;
        while (!in_ready[s] && t < 100) begin @(posedge clk); #1; t++; end
        in_valid[s] = 1'b1; xs[s] = 16'(x); ms[s] = 8'(m); mps[s] = mp_of(m); out_ready[s] = hold;
        @(posedge clk); #1;
        in_valid[s] = 1'b0; xs[s] = 16'($urandom); ms[s] = 8'($urandom); mps[s] = 2'($urandom);
        lat = 1; rdy_ok = 1'b1;
        while (!out_valid[s] && lat < 100) begin
            if (in_ready[s]) rdy_ok = 1'b0;
            @(posedge clk); #1; lat++;
        end
        if (!out_valid[s]) lat = -1;
        res = result[s]; er = err[s];
        out_ready[s] = 1'b1;
        @(posedge clk); #1;
        out_ready[s] = hold;
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            checks += 4;
            if (in_ready[s] !== 1'b1)  begin errors++; $display("FAIL reset_in_ready[%0d] got %b want 1", s, in_ready[s]); end
            if (out_valid[s] !== 1'b0) begin errors++; $display("FAIL reset_out_valid[%0d] got %b want 0", s, out_valid[s]); end
            if (result[s] !== 8'd0)    begin errors++; $display("FAIL reset_result[%0d] got %0d want 0", s, result[s]); end
            if (err[s] !== 1'b0)       begin errors++; $display("FAIL reset_err[%0d] got %b want 0", s, err[s]); end
        end
    endtask

    task automatic test_basic();
        logic [7:0] r; logic e; int lat; bit ok;
        run_op(0, 256, 17, 1'b0, r, e, lat, ok);
        checks += 4;
        if (r !== 8'd1)  begin errors++; $display("FAIL basic_result got %0d want 1", r); end
        if (e !== 1'b0)  begin errors++; $display("FAIL basic_err got %b want 0", e); end
        if (lat != 10)   begin errors++; $display("FAIL basic_latency got %0d want 10", lat); end
        if (!ok)         begin errors++; $display("FAIL basic_in_ready_busy got high want low"); end
    endtask

    task automatic test_boundary();
        logic [7:0] r; logic e; int lat; bit ok;
        run_op(0, 0, 17, 1'b0, r, e, lat, ok);
        checks++;
        if (r !== 8'd0)  begin errors++; $display("FAIL boundary_zero got %0d want 0", r); end
        run_op(0, 4351, 17, 1'b0, r, e, lat, ok);
        checks++;
        if (r !== 8'd16) begin errors++; $display("FAIL boundary_max got %0d want 16", r); end
    endtask

    task automatic test_radix();
        logic [7:0] r; logic e; int lat; bit ok;
        run_op(1, 256, 17, 1'b0, r, e, lat, ok);
        checks += 2;
        if (r !== 8'd1) begin errors++; $display("FAIL radix4_result got %0d want 1", r); end
        if (lat != 6)   begin errors++; $display("FAIL radix4_latency got %0d want 6", lat); end
        for (int x = 0; x < 4352; x++) begin
            run_op(1, x, 17, 1'b0, r, e, lat, ok);
            checks++;
            if (r !== ref_mont(x, 17) || e !== 1'b0 || lat != 6) begin
                errors++; $display("FAIL radix4_sweep x=%0d got %0d/%b/%0d want %0d/0/6", x, r, e, lat, ref_mont(x, 17));
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] r; logic e; int lat; bit ok;
        for (int i = 0; i < 300; i++) begin
            int s = int'($urandom_range(0, 1));
            int m = int'($urandom_range(1, 127)) * 2 + 1;
            int x = int'($urandom_range(0, m * 256 - 1));
            run_op(s, x, m, 1'(i % 3 == 0), r, e, lat, ok);
            checks++;
            if (r !== ref_mont(x, m) || e !== 1'b0 || lat != (s == 1 ? 6 : 10) || !ok) begin
                errors++; $display("FAIL random s=%0d x=%0d m=%0d got %0d/%b/%0d want %0d/0/%0d",
                                   s, x, m, r, e, lat, ref_mont(x, m), s == 1 ? 6 : 10);
            end
        end
    endtask

    task automatic test_error();
        logic [7:0] r; logic e; int lat; bit ok;
        run_op(0, 100, 16, 1'b0, r, e, lat, ok);
        checks += 3;
        if (e !== 1'b1) begin errors++; $display("FAIL error_flag got %b want 1", e); end
        if (r !== 8'd0) begin errors++; $display("FAIL error_result got %0d want 0", r); end
        if (lat != 1)   begin errors++; $display("FAIL error_latency got %0d want 1", lat); end
        run_op(0, 256, 17, 1'b0, r, e, lat, ok);
        checks++;
        if (r !== 8'd1 || e !== 1'b0) begin errors++; $display("FAIL error_recover got %0d/%b want 1/0", r, e); end
    endtask

    task automatic test_backpressure();
        logic [7:0] r; logic e; int lat; bit ok;
        int t = 0;
        in_valid[0] = 1'b1; xs[0] = 16'd4351; ms[0] = 8'd17; out_ready[0] = 1'b0;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        while (!out_valid[0] && t < 100) begin @(posedge clk); #1; t++; end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid[0] !== 1'b1 || result[0] !== 8'd16 || in_ready[0] !== 1'b0) begin
                errors++; $display("FAIL backpressure_hold cyc=%0d got v=%b r=%0d rdy=%b want 1/16/0",
                                   i, out_valid[0], result[0], in_ready[0]);
            end
            @(posedge clk); #1;
        end
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        checks++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
            errors++; $display("FAIL backpressure_release got rdy=%b v=%b want 1/0", in_ready[0], out_valid[0]);
        end
        run_op(0, 300, 17, 1'b0, r, e, lat, ok);
        checks++;
        if (r !== ref_mont(300, 17) || lat != 10) begin
            errors++; $display("FAIL backpressure_next got %0d/%0d want %0d/10", r, lat, ref_mont(300, 17));
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] r; logic e; int lat; bit ok;
        for (int i = 0; i < 4; i++) begin
            int x = int'($urandom_range(0, 4351));
            run_op(1, x, 17, 1'b1, r, e, lat, ok);
            checks++;
            if (r !== ref_mont(x, 17) || lat != 6 || !ok) begin
                errors++; $display("FAIL back_to_back x=%0d got %0d/%0d want %0d/6", x, r, lat, ref_mont(x, 17));
            end
        end
        out_ready[1] = 1'b0;
    endtask

    task automatic test_abort();
        logic [7:0] r; logic e; int lat; bit ok;
        in_valid[0] = 1'b1; xs[0] = 16'd4351; ms[0] = 8'd17;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || result[0] !== 8'd0 || err[0] !== 1'b0) begin
            errors++; $display("FAIL abort_outputs got rdy=%b v=%b r=%0d e=%b want 1/0/0/0",
                               in_ready[0], out_valid[0], result[0], err[0]);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(0, 1000, 17, 1'b0, r, e, lat, ok);
        checks++;
        if (r !== ref_mont(1000, 17) || lat != 10) begin
            errors++; $display("FAIL abort_fresh got %0d/%0d want %0d/10", r, lat, ref_mont(1000, 17));
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            in_valid[s] = 1'b0; out_ready[s] = 1'b0; xs[s] = '0; ms[s] = '0; mps[s] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_basic();
        test_boundary();
        test_error();
        test_backpressure();
        test_back_to_back();
        test_abort();
        test_radix();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
